// File: rtl/cam_pkg.sv
// Shared types and constants for the camera gray capture path.
// FSM states, luma weights and default crop window.
package cam_pkg;

    typedef enum logic [1:0] {
        WAIT_VS  = 2'd0,
        WAIT_ACT = 2'd1,
        ACTIVE   = 2'd2
    } cam_state_e;

    localparam int CAM_IMG_W = 640;
    localparam int CAM_IMG_H = 480;

    localparam logic [7:0] LUMA_KR = 8'd77;
    localparam logic [7:0] LUMA_KG = 8'd150;
    localparam logic [7:0] LUMA_KB = 8'd29;

endpackage

// File: rtl/rgb565_to_luma.sv
// RGB565 byte pair to 8-bit luma, three registered stages.
// Stage A expands, stage B multiplies, stage C sums and shifts.
module rgb565_to_luma
    import cam_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       vld_i,
    input  logic [7:0] byte0_i,
    input  logic [7:0] byte1_i,
    output logic       vld_o,
    output logic [7:0] luma_o
);

    logic [4:0]  r5;
    logic [5:0]  g6;
    logic [4:0]  b5;
    logic [7:0]  r8_d, g8_d, b8_d;
    logic [7:0]  r8_q, g8_q, b8_q;
    logic        va_d, va_q;
    logic [15:0] pr_d, pg_d, pb_d;
    logic [15:0] pr_q, pg_q, pb_q;
    logic        vb_d, vb_q;
    logic [15:0] sum_d;
    logic [7:0]  luma_d, luma_q;
    logic        vc_d, vc_q;

    // Next-state for all three stages; luma holds between valid pixels
    always_comb begin
        r5     = byte0_i[7:3];
        g6     = {byte0_i[2:0], byte1_i[7:5]};
        b5     = byte1_i[4:0];
        r8_d   = {r5, r5[4:2]};
        g8_d   = {g6, g6[5:4]};
        b8_d   = {b5, b5[4:2]};
        va_d   = vld_i;
        pr_d   = {8'd0, LUMA_KR} * {8'd0, r8_q};
        pg_d   = {8'd0, LUMA_KG} * {8'd0, g8_q};
        pb_d   = {8'd0, LUMA_KB} * {8'd0, b8_q};
        vb_d   = va_q;
        sum_d  = pr_q + pg_q + pb_q;
        vc_d   = vb_q;
        luma_d = vb_q ? 8'(sum_d >> 8) : luma_q;
    end

    // Pipeline registers; valids flush on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r8_q   <= '0;
            g8_q   <= '0;
            b8_q   <= '0;
            va_q   <= 1'b0;
            pr_q   <= '0;
            pg_q   <= '0;
            pb_q   <= '0;
            vb_q   <= 1'b0;
            luma_q <= '0;
            vc_q   <= 1'b0;
        end else begin
            r8_q   <= r8_d;
            g8_q   <= g8_d;
            b8_q   <= b8_d;
            va_q   <= va_d;
            pr_q   <= pr_d;
            pg_q   <= pg_d;
            pb_q   <= pb_d;
            vb_q   <= vb_d;
            luma_q <= luma_d;
            vc_q   <= vc_d;
        end
    end

    assign vld_o  = vc_q;
    assign luma_o = luma_q;

endmodule

// File: rtl/cam_gray_capture.sv
// DVP RGB565 capture: frame sync FSM, byte pairing, crop, luma.
// Status pulses ride a delay line matching the luma pipeline.
module cam_gray_capture
    import cam_pkg::*;
#(
    parameter int IMG_W = CAM_IMG_W,
    parameter int IMG_H = CAM_IMG_H
) (
    input  logic       PixelClk,
    input  logic       reset,
    input  logic [7:0] cam_data,
    input  logic       cam_href,
    input  logic       cam_vsync,
    output logic [7:0] pixdata,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_done,
    output logic       line_err
);

    localparam logic [9:0] W_LIM = 10'(IMG_W);
    localparam logic [8:0] H_LIM = 9'(IMG_H);

    cam_state_e  state_d, state_q;
    logic [7:0]  data_d, data_q;
    logic        href_d, href_q;
    logic        vend_d, vend_q;
    logic        vstart_d, vstart_q;
    logic        vsync_d, vsync_q;
    logic        phase_d, phase_q;
    logic [7:0]  byte0_d, byte0_q;
    logic        in_line_d, in_line_q;
    logic [9:0]  pix_d, pix_q;
    logic [8:0]  line_d, line_q;
    logic [2:0]  lerr_d, lerr_q;
    logic [2:0]  done_d, done_q;
    logic        pix_fire, line_end, lerr_ev, pix_vld;

    // Frame FSM on raw inputs; input register gates href outside ACTIVE
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_VS:  if (cam_vsync)  state_d = WAIT_ACT;
            WAIT_ACT: if (!cam_vsync) state_d = ACTIVE;
            ACTIVE:   if (cam_vsync)  state_d = WAIT_ACT;
            default:  state_d = WAIT_VS;
        endcase
        data_d   = cam_data;
        href_d   = (state_q == ACTIVE) && cam_href && !cam_vsync;
        vend_d   = (state_q == ACTIVE) && cam_vsync;
        vstart_d = (state_q == WAIT_ACT) && !cam_vsync;
    end

    // Byte pairing, pixel/line counters and crop decision
    always_comb begin
        pix_fire  = href_q && phase_q;
        line_end  = in_line_q && !href_q && !vend_q;
        pix_vld   = pix_fire && (pix_q < W_LIM) && (line_q < H_LIM);
        lerr_ev   = line_end && !((pix_q == W_LIM) && !phase_q);
        phase_d   = href_q ? ~phase_q : 1'b0;
        byte0_d   = (href_q && !phase_q) ? data_q : byte0_q;
        in_line_d = href_q;
        pix_d     = pix_q;
        if (!href_q)
            pix_d = '0;
        else if (pix_fire && (pix_q != 10'h3FF))
            pix_d = pix_q + 10'd1;
        line_d = line_q;
        if (vstart_q)
            line_d = '0;
        else if (line_end && (line_q != 9'h1FF))
            line_d = line_q + 9'd1;
    end

    // Status delay line and vsync output level
    always_comb begin
        lerr_d  = {lerr_q[1:0], lerr_ev};
        done_d  = {done_q[1:0], vend_q};
        vsync_d = vsync_q;
        if (done_q[1])
            vsync_d = 1'b1;
        if ((state_q == WAIT_ACT) && !cam_vsync)
            vsync_d = 1'b0;
    end

    // Control and datapath state registers
    always_ff @(posedge PixelClk) begin
        if (reset) begin
            state_q   <= WAIT_VS;
            data_q    <= '0;
            href_q    <= 1'b0;
            vend_q    <= 1'b0;
            vstart_q  <= 1'b0;
            vsync_q   <= 1'b1;
            phase_q   <= 1'b0;
            byte0_q   <= '0;
            in_line_q <= 1'b0;
            pix_q     <= '0;
            line_q    <= '0;
            lerr_q    <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            href_q    <= href_d;
            vend_q    <= vend_d;
            vstart_q  <= vstart_d;
            vsync_q   <= vsync_d;
            phase_q   <= phase_d;
            byte0_q   <= byte0_d;
            in_line_q <= in_line_d;
            pix_q     <= pix_d;
            line_q    <= line_d;
            lerr_q    <= lerr_d;
            done_q    <= done_d;
        end
    end

    rgb565_to_luma u_luma (
        .clk     (PixelClk),
        .rst     (reset),
        .vld_i   (pix_vld),
        .byte0_i (byte0_q),
        .byte1_i (data_q),
        .vld_o   (hsync),
        .luma_o  (pixdata)
    );

    assign vsync      = vsync_q;
    assign frame_done = done_q[2];
    assign line_err   = lerr_q[2];

endmodule

// File: tb/tb_cam_gray_capture.sv
// Directed bench for cam_gray_capture on a reduced 16x8 window.
// Vector table for luma plus frame-level sequences.
module tb_cam_gray_capture;

    localparam int W = 16;
    localparam int H = 8;

    typedef struct packed {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] y;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cam_data;
    logic       cam_href;
    logic       cam_vsync;
    logic [7:0] pixdata;
    logic       hsync;
    logic       vsync;
    logic       frame_done;
    logic       line_err;

    int n_chk  = 0;
    int n_fail = 0;

    int   strobes = 0;
    int   lerrs   = 0;
    int   dones   = 0;
    int   pix_bad = 0;
    int   vs_bad  = 0;
    int   dbl_bad = 0;
    logic prev_hs = 1'b0;

    logic [7:0] exp_pix = 8'd0;

    vec_t vt [6];
    int   lens [4];

    always #5 clk = ~clk;

    cam_gray_capture #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .PixelClk   (clk),
        .reset      (reset),
        .cam_data   (cam_data),
        .cam_href   (cam_href),
        .cam_vsync  (cam_vsync),
        .pixdata    (pixdata),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_done (frame_done),
        .line_err   (line_err)
    );

    // Output monitor sampled on the falling edge
    always @(negedge clk) begin
        if (hsync) begin
            strobes <= strobes + 1;
            if (pixdata !== exp_pix) pix_bad <= pix_bad + 1;
            if (vsync !== 1'b0)      vs_bad  <= vs_bad + 1;
            if (prev_hs)             dbl_bad <= dbl_bad + 1;
        end
        if (line_err)   lerrs <= lerrs + 1;
        if (frame_done) dones <= dones + 1;
        prev_hs <= hsync;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] d, input logic h, input logic v);
        cam_data  = d;
        cam_href  = h;
        cam_vsync = v;
        @(posedge clk);
        #1;
    endtask

    task automatic line(input int n, input logic [7:0] b0,
                        input logic [7:0] b1);
        for (int i = 0; i < n; i++)
            cyc((i % 2 == 0) ? b0 : b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(8'h00, 1'b0, 1'b0);
    endtask

    task automatic frame_start();
        for (int i = 0; i < 3; i++)
            cyc(8'h00, 1'b0, 1'b1);
        check("fs_vsync_hi", vsync, 1);
        cyc(8'h00, 1'b0, 1'b0);
        check("fs_vsync_fall", vsync, 0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
    endtask

    task automatic frame_end(input logic hold);
        cyc(8'h00, hold, 1'b1);
        check("fe_done_c1", frame_done, 0);
        cyc(8'h00, 1'b0, 1'b1);
        check("fe_done_c2", frame_done, 0);
        cyc(8'h00, 1'b0, 1'b1);
        check("fe_done_c3", frame_done, 0);
        check("fe_vsync_c3", vsync, 0);
        cyc(8'h00, 1'b0, 1'b1);
        check("fe_done_c4", frame_done, 1);
        check("fe_vsync_c4", vsync, 1);
        cyc(8'h00, 1'b0, 1'b1);
        check("fe_done_c5", frame_done, 0);
        cyc(8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        int s0, l0, d0;

        vt[0] = '{8'hF8, 8'h00, 8'd76};
        vt[1] = '{8'h07, 8'hE0, 8'd149};
        vt[2] = '{8'h00, 8'h1F, 8'd28};
        vt[3] = '{8'h00, 8'h00, 8'd0};
        vt[4] = '{8'h84, 8'h10, 8'd130};
        vt[5] = '{8'h12, 8'h34, 8'd63};
        lens  = '{34, 28, 32, 33};

        reset = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc(8'h00, 1'b0, 1'b0);
        check("rst_pixdata", pixdata, 0);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 1);
        check("rst_done", frame_done, 0);
        check("rst_lerr", line_err, 0);
        reset = 1'b0;

        // stream already mid-frame at reset release
        exp_pix = 8'd255;
        s0 = strobes;
        for (int i = 0; i < 3; i++)
            line(2 * W, 8'hFF, 8'hFF);
        check("midframe_strobes", strobes - s0, 0);
        check("midframe_vsync", vsync, 1);

        // single-pixel lines from the vector table
        frame_start();
        s0 = strobes;
        l0 = lerrs;
        for (int i = 0; i < 6; i++) begin
            exp_pix = vt[i].y;
            cyc(vt[i].b0, 1'b1, 1'b0);
            cyc(vt[i].b1, 1'b1, 1'b0);
            cyc(8'h00, 1'b0, 1'b0);
            cyc(8'h00, 1'b0, 1'b0);
            check("vec_early_hsync", hsync, 0);
            cyc(8'h00, 1'b0, 1'b0);
            check("vec_hsync", hsync, 1);
            check("vec_pixdata", pixdata, vt[i].y);
            cyc(8'h00, 1'b0, 1'b0);
            check("vec_hsync_off", hsync, 0);
            check("vec_pix_hold", pixdata, vt[i].y);
            check("vec_lerr", line_err, 1);
            cyc(8'h00, 1'b0, 1'b0);
            cyc(8'h00, 1'b0, 1'b0);
        end
        frame_end(1'b0);
        check("vec_strobes", strobes - s0, 6);
        check("vec_lerrs", lerrs - l0, 6);

        // full white frame
        exp_pix = 8'd255;
        s0 = strobes;
        l0 = lerrs;
        d0 = dones;
        frame_start();
        for (int i = 0; i < H; i++)
            line(2 * W, 8'hFF, 8'hFF);
        frame_end(1'b0);
        check("white_strobes", strobes - s0, W * H);
        check("white_lerrs", lerrs - l0, 0);
        check("white_dones", dones - d0, 1);

        // long, short, exact and odd-length lines
        exp_pix = 8'd76;
        s0 = strobes;
        l0 = lerrs;
        frame_start();
        for (int i = 0; i < 4; i++)
            line(lens[i], 8'hF8, 8'h00);
        frame_end(1'b0);
        check("len_strobes", strobes - s0, 62);
        check("len_lerrs", lerrs - l0, 3);

        // frame taller than the crop window
        exp_pix = 8'd255;
        s0 = strobes;
        l0 = lerrs;
        d0 = dones;
        frame_start();
        for (int i = 0; i < H + 2; i++)
            line(2 * W, 8'hFF, 8'hFF);
        frame_end(1'b0);
        check("tall_strobes", strobes - s0, W * H);
        check("tall_lerrs", lerrs - l0, 0);
        check("tall_dones", dones - d0, 1);

        // vsync rises while href is still high
        s0 = strobes;
        l0 = lerrs;
        d0 = dones;
        frame_start();
        for (int i = 0; i < 10; i++)
            cyc(8'hFF, 1'b1, 1'b0);
        frame_end(1'b1);
        check("vswin_strobes", strobes - s0, 5);
        check("vswin_lerrs", lerrs - l0, 0);
        check("vswin_dones", dones - d0, 1);

        // reset in the middle of a line
        frame_start();
        line(2 * W, 8'hFF, 8'hFF);
        line(2 * W, 8'hFF, 8'hFF);
        for (int i = 0; i < 12; i++)
            cyc(8'hFF, 1'b1, 1'b0);
        reset = 1'b1;
        cyc(8'hFF, 1'b1, 1'b0);
        check("midrst_hsync", hsync, 0);
        check("midrst_vsync", vsync, 1);
        s0 = strobes;
        d0 = dones;
        cyc(8'hFF, 1'b1, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++)
            cyc(8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(8'h00, 1'b0, 1'b0);
        line(2 * W, 8'hFF, 8'hFF);
        line(2 * W, 8'hFF, 8'hFF);
        for (int i = 0; i < 6; i++)
            cyc(8'h00, 1'b0, 1'b1);
        check("midrst_strobes", strobes - s0, 0);
        check("midrst_dones", dones - d0, 0);
        s0 = strobes;
        frame_start();
        for (int i = 0; i < H; i++)
            line(2 * W, 8'hFF, 8'hFF);
        frame_end(1'b0);
        check("postrst_strobes", strobes - s0, W * H);

        cyc(8'h00, 1'b0, 1'b1);
        check("pix_values", pix_bad, 0);
        check("strobe_vsync_low", vs_bad, 0);
        check("strobe_spacing", dbl_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_gray_capture.md
# cam_gray_capture

Front-end capture stage between the DVP camera port and the binary-video LCD stage. It samples the camera byte stream (RGB565, two bytes per pixel), forms 8-bit luma and crops to a 640x480 window. It emits the `pixdata` / `hsync` / `vsync` triple that the thresholding/frame-buffer stage consumes. It also reports frame-complete and line-length errors for debug LEDs.

## Interface
- `IMG_W`, 640, pixels emitted per line (crop width)
- `IMG_H`, 480, lines emitted per frame (crop height)
- `PixelClk`  in  1  system/pixel clock; camera signals arrive already synchronous to it
- `reset`  in  1  synchronous, active-high
- `cam_data`  in  8  DVP byte bus
- `cam_href`  in  1  line-valid, high while bytes of a line are present
- `cam_vsync`  in  1  high during vertical blanking
- `pixdata`  out  8  luma of current pixel
- `hsync`  out  1  one-cycle pixel strobe; downstream advances its write address on every high cycle
- `vsync`  out  1  low while a frame is being emitted, high otherwise
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame
- `line_err`  out  1  one-cycle pulse when a line ends with a byte count ≠ 2*IMG_W

## Operation
- All outputs reset to 0, except `vsync`, which resets to 1. The FSM enters WAIT_VS, and the pixel counter, line counter and byte phase all clear.
- FSM states:
  - WAIT_VS: go to WAIT_ACT on `cam_vsync`=1. This guarantees capture never starts mid-frame.
  - WAIT_ACT: go to ACTIVE on `cam_vsync`=0. `vsync` output drops to 0 on this transition.
  - ACTIVE: go to WAIT_ACT on `cam_vsync`=1. On this exit, pulse `frame_done` and set `vsync`=1.
- Byte pairing:
  - Byte phase toggles on each cycle with `cam_href`=1 and clears whenever `cam_href`=0.
  - Phase 0 byte = {R[4:0],G[5:3]}; phase 1 byte = {G[2:0],B[4:0]}.
  - A pixel is formed on each phase-1 byte.
- Expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Luma: Y=(77*R8+150*G8+29*B8)>>8, using a 16-bit accumulator. The coefficients sum to 256, so there is no overflow and Y≤255. Truncate; no rounding.
- Crop:
  - Pixel counter (10 bit) counts formed pixels in the line.
  - Line counter (9 bit) counts lines that had at least one byte.
  - A pixel is emitted (`hsync`=1) only if pixel count < IMG_W and line count < IMG_H, both taken before increment.
  - Excess pixels and lines are dropped silently.
- Line end (falling `cam_href`): if the byte count ≠ 2*IMG_W, pulse `line_err`. The pixel counter clears and the line counter increments. An odd trailing byte is discarded.
- Outside ACTIVE, `cam_href` is ignored and no strobes are emitted. The line counter clears on entry to ACTIVE.
- Reset mid-frame: return to WAIT_VS and flush pipeline valids. No strobe may appear after reset asserts.

## Timing
- Pipeline of 4 registered stages: input register → pair/expand → three products → sum/shift/output.
- If the phase-1 byte is on `cam_data` in cycle n, `pixdata`/`hsync` are valid in cycle n+4.
- `hsync` is high for exactly one cycle per emitted pixel. Across a line it is high at most every other cycle.
- `pixdata` holds its last value while `hsync`=0.
- `vsync` falls in the cycle after `cam_vsync` is first sampled low in WAIT_ACT.
- `vsync` rises, and `frame_done` pulses, 4 cycles after `cam_vsync` is sampled high in ACTIVE. This delay lets the last in-flight pixel's strobe precede both.
- `line_err` pulses 4 cycles after the first `cam_href`=0 sample, aligned with the pipeline.
- If `cam_href` and `cam_vsync` are both high in the same cycle, `cam_vsync` wins: the line is abandoned without a `line_err`.

## Structure
- Shared package `cam_pkg` holds:
  - the FSM state typedef (WAIT_VS, WAIT_ACT, ACTIVE);
  - luma coefficient constants (77/150/29);
  - default IMG_W/IMG_H.
- One natural sub-module, `rgb565_to_luma`: expansion plus the 3-stage multiply/sum. Pure pipeline with a valid-in/valid-out pair, no control.

## Test plan
- One 640x480 frame of white (0xFF,0xFF) after a leading blanking period → 307200 `hsync` strobes, all `pixdata`=255; `vsync` low across them; single `frame_done`.
- Colour pixels:
  - 0xF8,0x00 → 76
  - 0x07,0xE0 → 149
  - 0x00,0x1F → 28
  - 0x00,0x00 → 0
  - each appears exactly 4 cycles after the second byte.
- Stream starts mid-frame (`cam_vsync` low at reset release) → no strobes until a full `cam_vsync` high→low sequence is seen.
- Line of 1300 bytes, then a line of 1200 bytes:
  - first line → 640 strobes, `line_err` pulse;
  - second line → 600 strobes, `line_err` pulse;
  - 1280-byte lines → no pulse.
- 500-line frame → only the first 480 lines strobe; `frame_done` still pulses once at `cam_vsync` rise.
- `reset` asserted at pixel 300 of line 10 → the next cycle has `hsync`=0 and `vsync`=1, and there are no strobes until the next full frame.
